dock_cfg_sequencer: RTL and testbench
=====================================

# dock_cfg_sequencer

Sequencer and arbiter for the Dock's shared 8-bit configuration bus, which carries the address-decoder windows below `IRQ_CFG_BASE` and the interrupt-router registers at and above it.
- After reset it streams a boot image of `{addr,data}` entries from a synchronous ROM onto the bus.
- It then shares the bus round-robin between `NUM_REQ` host write ports.
- While `irq_lock` is high, it drops host writes into the interrupt-router region and counts them.
- Its outputs drive the Dock top-level `cfg_we`/`cfg_addr`/`cfg_wdata`; the top-level `cfg_clk` is tied to `clk`.

## Interface
Parameters:
- `NUM_REQ`, 2: number of host requesters (≥1).
- `INIT_LEN`, 64: maximum boot-image entries.
- `ROM_AW`, 6: ROM address width; 2^ROM_AW ≥ INIT_LEN.
- `IRQ_CFG_BASE`, 8'hC0: first config address of the interrupt-router region.

Ports:
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, **synchronous, active-high**.
- `rom_addr` out ROM_AW: boot-image entry index.
- `rom_data` in 16: entry `{cfg_addr[15:8], cfg_wdata[7:0]}`; valid one cycle after `rom_addr`.
- `req_valid` in NUM_REQ: per-requester write request.
- `req_addr` in NUM_REQ*8: requester i occupies bits [8i+7:8i].
- `req_wdata` in NUM_REQ*8: same packing as `req_addr`.
- `req_ready` out NUM_REQ: one-cycle accept pulse.
- `irq_lock` in 1: block host writes with address ≥ IRQ_CFG_BASE.
- `cfg_we` out 1: config write strobe.
- `cfg_addr` out 8: config write address.
- `cfg_wdata` out 8: config write data.
- `init_done` out 1: boot image finished.
- `drop_cnt` out 8: count of dropped locked writes, saturating.

## Operation
States: `INIT_FETCH`, `INIT_WRITE`, `IDLE`, `HOST_WRITE`, `GAP`.

Boot image:
- `INIT_FETCH` drives `rom_addr` = entry index k, then moves to `INIT_WRITE`.
- `INIT_WRITE` handles entry k as follows:
  - If `rom_data` = 16'hFFFF, the entry is a terminator: no write, go to `IDLE`.
  - Otherwise assert `cfg_we` = 1 with `cfg_addr` = rom_data[15:8] and `cfg_wdata` = rom_data[7:0].
  - After the write, if k = INIT_LEN-1 go to `IDLE`; else k ← k+1 and return to `INIT_FETCH`.
- `init_done` rises on entry to `IDLE` and stays high until reset.

Host arbitration:
- In `IDLE` with any `req_valid` high, pick winner w by round-robin: search starts at `last_grant`+1 and wraps modulo NUM_REQ.
- Register w's address and data, update `last_grant` ← w, go to `HOST_WRITE`.
- `HOST_WRITE` lasts one cycle:
  - `req_ready[w]` = 1.
  - `cfg_we` = 1, unless `irq_lock` (sampled in this cycle) is high and the registered address ≥ IRQ_CFG_BASE.
  - In that locked case `cfg_we` stays 0, the write is dropped, and `drop_cnt` increments, saturating at 8'hFF.
  - Next state is `GAP`.
- `GAP` lasts one cycle with `cfg_we` = 0, then returns to `IDLE`.

Requester rules:
- Hold `req_valid`, `req_addr` and `req_wdata` stable until `req_ready` is seen.
- The request is consumed on the `req_ready` cycle; drop `req_valid` or present the next request after it.
- `req_valid` during boot is ignored: `req_ready` stays 0.

Other rules:
- `cfg_addr`/`cfg_wdata` hold their last value when `cfg_we` = 0.
- At most one `req_ready` bit is high in any cycle.

## Timing
Reset values:
- FSM = `INIT_FETCH`, k = 0, `rom_addr` = 0.
- `cfg_we` = 0, `cfg_addr` = 0, `cfg_wdata` = 0.
- `req_ready` = 0, `init_done` = 0, `drop_cnt` = 0.
- `last_grant` = NUM_REQ-1, so requester 0 wins first.

Boot latency:
- Cycle 0 is the first edge after `rst` falls.
- Entry k's write strobe appears at cycle 2k+1.
- With no terminator, `init_done` = 1 at cycle 2·INIT_LEN.
- A terminator at entry k gives `init_done` at cycle 2k+2.

Host latency:
- `req_valid` sampled in `IDLE` at cycle N → `cfg_we` and `req_ready` at N+1, `GAP` at N+2, `IDLE` at N+3.
- Sustained throughput is one write per 3 cycles.
- With all requesters continuously valid, each gets one grant per NUM_REQ writes.

Reset mid-operation: `rst` high at any edge aborts the current state, forces `cfg_we` = 0 at that edge, and restarts the boot image from entry 0. A pending host request is not acknowledged.

## Test plan
- **Boot, no terminator:** INIT_LEN=4, ROM {C1_01, 10_22, 11_33, 12_44} → `cfg_we` at cycles 1,3,5,7 with those addr/data pairs; `init_done` = 1 at cycle 8.
- **Boot, terminator:** ROM entry 1 = FFFF → exactly one write (C1/01); `init_done` at cycle 4; requests before that get no `req_ready`.
- **Round-robin:** NUM_REQ=2, both valid continuously after boot → grants 0,1,0,1; `req_ready` 3 cycles apart; `cfg_addr` alternates between each port's address.
- **Lock:** `irq_lock` = 1, req0 writes C3/55 → `req_ready[0]` pulses, `cfg_we` stays 0, `drop_cnt` = 1. Then req0 writes 20/66 → `cfg_we` = 1 with 20/66.
- **Saturation:** 300 locked writes → `drop_cnt` stops at 8'hFF.
- **Reset mid-grant:** `rst` asserted during `HOST_WRITE` → `cfg_we` = 0 and `init_done` = 0 next cycle; boot restarts at entry 0; `last_grant` reset so requester 0 wins first.

Source files
------------

// File: rtl/dock_cfg_sequencer_if.sv
// Host write-request and configuration-bus signals of the Dock config sequencer.
// The sequencer uses the slave modport; hosts and the Dock top use master.
interface dock_cfg_sequencer_if #(
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_addr;
  logic [NUM_REQ*8-1:0] req_wdata;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [7:0]           cfg_wdata;

  modport master (
    output req_valid, req_addr, req_wdata,
    input  req_ready, cfg_we, cfg_addr, cfg_wdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata,
    output req_ready, cfg_we, cfg_addr, cfg_wdata
  );
endinterface

// File: rtl/dock_cfg_sequencer.sv
// Dock config-bus sequencer: streams the boot image from ROM, then arbitrates
// host writes round-robin, dropping interrupt-router writes while irq_lock is set.
module dock_cfg_sequencer #(
  parameter int         NUM_REQ      = 2,
  parameter int         INIT_LEN     = 64,
  parameter int         ROM_AW       = 6,
  parameter logic [7:0] IRQ_CFG_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              irq_lock,
  output logic              init_done,
  output logic [7:0]        drop_cnt,
  dock_cfg_sequencer_if.slave bus
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [2:0] {
    INIT_FETCH,
    INIT_WRITE,
    IDLE,
    HOST_WRITE,
    GAP
  } state_t;

  state_t      state;
  logic [GW-1:0] last_grant;
  logic [7:0]  hold_addr;
  logic [7:0]  hold_wdata;
  logic        any_req;
  int unsigned win;

  // Scan from lowest to highest priority so the last hit (last_grant+1 side) wins.
  always_comb begin
    any_req = |bus.req_valid;
    win     = 32'(last_grant);
    for (int unsigned i = 0; i < NR; i++) begin
      int unsigned idx;
      idx = (32'(last_grant) + NR - i) % NR;
      if (bus.req_valid[idx]) win = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= INIT_FETCH;
      rom_addr      <= '0;
      bus.cfg_we    <= 1'b0;
      bus.cfg_addr  <= '0;
      bus.cfg_wdata <= '0;
      bus.req_ready <= '0;
      init_done     <= 1'b0;
      drop_cnt      <= '0;
      last_grant    <= GW'(NUM_REQ - 1);
      hold_addr     <= '0;
      hold_wdata    <= '0;
    end else begin
      bus.cfg_we    <= 1'b0;
      bus.req_ready <= '0;
      case (state)
        INIT_FETCH: state <= INIT_WRITE;

        INIT_WRITE: begin
          if (rom_data == 16'hFFFF) begin
            state <= IDLE;
          end else begin
            bus.cfg_we    <= 1'b1;
            bus.cfg_addr  <= rom_data[15:8];
            bus.cfg_wdata <= rom_data[7:0];
            if (rom_addr == ROM_AW'(INIT_LEN - 1)) begin
              state <= IDLE;
            end else begin
              rom_addr <= rom_addr + 1'b1;
              state    <= INIT_FETCH;
            end
          end
        end

        IDLE: begin
          init_done <= 1'b1;
          if (any_req) begin
            last_grant <= GW'(win);
            hold_addr  <= bus.req_addr[8*win +: 8];
            hold_wdata <= bus.req_wdata[8*win +: 8];
            state      <= HOST_WRITE;
          end
        end

        HOST_WRITE: begin
          bus.req_ready <= NUM_REQ'(1) << last_grant;
          if (irq_lock && (hold_addr >= IRQ_CFG_BASE)) begin
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
          end else begin
            bus.cfg_we    <= 1'b1;
            bus.cfg_addr  <= hold_addr;
            bus.cfg_wdata <= hold_wdata;
          end
          state <= GAP;
        end

        GAP: state <= IDLE;

        default: state <= INIT_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_dock_cfg_sequencer.sv
// Scoreboard bench for dock_cfg_sequencer: a queue-level round-robin model predicts
// every config write / request acknowledge, and a monitor compares them as they appear.
module tb_dock_cfg_sequencer;
  localparam int NUM_REQ  = 2;
  localparam int INIT_LEN = 4;
  localparam int ROM_AW   = 2;

  typedef struct {
    logic [7:0] a;
    logic [7:0] d;
  } rq_t;

  typedef struct {
    int         port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] drop;
    int         cyc;
  } ev_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              irq_lock = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [15:0]       rom_data = '0;
  logic              init_done;
  logic [7:0]        drop_cnt;

  dock_cfg_sequencer_if #(.NUM_REQ(NUM_REQ)) bus_if ();

  dock_cfg_sequencer #(
    .NUM_REQ(NUM_REQ),
    .INIT_LEN(INIT_LEN),
    .ROM_AW(ROM_AW),
    .IRQ_CFG_BASE(8'hC0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .irq_lock(irq_lock),
    .init_done(init_done),
    .drop_cnt(drop_cnt),
    .bus(bus_if)
  );

  always #5 clk = ~clk;

  logic [15:0] rom_mem [INIT_LEN];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = -1;
  always @(posedge clk) cyc <= rst ? -1 : cyc + 1;

  int  vectors = 0;
  int  miscompares = 0;
  ev_t sb [$];
  rq_t drv_q [NUM_REQ][$];
  rq_t mdl_q [NUM_REQ][$];
  bit  hold_drv = 1'b0;

  int         mdl_last;
  int         mdl_drop;
  logic [7:0] mdl_addr;
  logic [7:0] mdl_data;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mdl_last = NUM_REQ - 1;
    mdl_drop = 0;
    mdl_addr = '0;
    mdl_data = '0;
  endfunction

  function automatic int push_boot();
    int  done;
    ev_t e;
    done = 2 * INIT_LEN;
    for (int k = 0; k < INIT_LEN; k++) begin
      if (rom_mem[k] == 16'hFFFF) begin
        done = 2 * k + 2;
        break;
      end
      mdl_addr = rom_mem[k][15:8];
      mdl_data = rom_mem[k][7:0];
      e.port = -1; e.we = 1'b1; e.addr = mdl_addr; e.data = mdl_data;
      e.drop = 8'(mdl_drop); e.cyc = 2 * k + 1;
      sb.push_back(e);
    end
    return done;
  endfunction

  task automatic add_req(input int p, input logic [7:0] a, input logic [7:0] d);
    rq_t r;
    r.a = a; r.d = d;
    drv_q[p].push_back(r);
    mdl_q[p].push_back(r);
  endtask

  // Serve pending queues in rotating order, one request per grant.
  function automatic void model_run();
    int  p;
    int  left;
    rq_t r;
    ev_t e;
    forever begin
      left = 0;
      for (int q = 0; q < NUM_REQ; q++) left += mdl_q[q].size();
      if (left == 0) break;
      p = mdl_last;
      for (int i = 1; i <= NUM_REQ; i++) begin
        p = (mdl_last + i) % NUM_REQ;
        if (mdl_q[p].size() > 0) break;
      end
      r = mdl_q[p].pop_front();
      e.we = !(irq_lock && (r.a >= 8'hC0));
      if (e.we) begin
        mdl_addr = r.a;
        mdl_data = r.d;
      end else if (mdl_drop < 255) begin
        mdl_drop++;
      end
      e.port = p; e.addr = mdl_addr; e.data = mdl_data;
      e.drop = 8'(mdl_drop); e.cyc = -1;
      sb.push_back(e);
      mdl_last = p;
    end
  endfunction

  // Requester driver: holds each request until its req_ready pulse is seen.
  initial begin
    bus_if.req_valid = '0;
    bus_if.req_addr  = '0;
    bus_if.req_wdata = '0;
    forever begin
      @(negedge clk);
      if (!hold_drv) begin
        for (int p = 0; p < NUM_REQ; p++) begin
          if (bus_if.req_ready[p] && drv_q[p].size() > 0) void'(drv_q[p].pop_front());
          if (drv_q[p].size() > 0) begin
            bus_if.req_valid[p]         = 1'b1;
            bus_if.req_addr[8*p +: 8]   = drv_q[p][0].a;
            bus_if.req_wdata[8*p +: 8]  = drv_q[p][0].d;
          end else begin
            bus_if.req_valid[p] = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: every write strobe or acknowledge must match the next expected event.
  initial begin
    ev_t e;
    int  exp_ready;
    forever begin
      @(negedge clk);
      if (!rst && (bus_if.cfg_we || (|bus_if.req_ready))) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {bus_if.cfg_we, bus_if.req_ready}, 0);
        end else begin
          e = sb.pop_front();
          exp_ready = (e.port < 0) ? 0 : (1 << e.port);
          check("req_ready", bus_if.req_ready, exp_ready);
          check("cfg_we", bus_if.cfg_we, e.we);
          check("cfg_addr", bus_if.cfg_addr, e.addr);
          check("cfg_wdata", bus_if.cfg_wdata, e.data);
          check("drop_cnt", drop_cnt, e.drop);
          if (e.cyc >= 0) check("boot_write_cycle", cyc, e.cyc);
        end
      end
    end
  end

  task automatic reset_checks(input string tag);
    check({tag, "_cfg_we"}, bus_if.cfg_we, 0);
    check({tag, "_cfg_addr"}, bus_if.cfg_addr, 0);
    check({tag, "_cfg_wdata"}, bus_if.cfg_wdata, 0);
    check({tag, "_req_ready"}, bus_if.req_ready, 0);
    check({tag, "_init_done"}, init_done, 0);
    check({tag, "_drop_cnt"}, drop_cnt, 0);
    check({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  task automatic wait_done(input int done);
    int t = 0;
    while (cyc != done - 1 && t < done + 10) begin
      @(negedge clk);
      t++;
    end
    check("init_done_before", init_done, 0);
    check("init_done_cycle", cyc, done - 1);
    @(negedge clk);
    check("init_done_at", init_done, 1);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    int left;
    left = sb.size();
    for (int p = 0; p < NUM_REQ; p++) left += drv_q[p].size();
    while (t < budget && left != 0) begin
      @(negedge clk);
      t++;
      left = sb.size();
      for (int p = 0; p < NUM_REQ; p++) left += drv_q[p].size();
    end
    check("phase_complete_pending", left, 0);
    if (left != 0) begin
      sb.delete();
      for (int p = 0; p < NUM_REQ; p++) drv_q[p].delete();
    end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int done;
    int n;
    rom_mem[0] = 16'hC101;
    rom_mem[1] = 16'h1022;
    rom_mem[2] = 16'h1133;
    rom_mem[3] = 16'h1244;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks("reset");

    // Full boot image, no terminator.
    model_reset();
    done = push_boot();
    rst = 1'b0;
    wait_done(done);
    wait_idle(100);

    // Both requesters continuously valid: strict alternation from port 0.
    irq_lock = 1'b0;
    for (int j = 0; j < 4; j++) begin
      add_req(0, 8'($urandom_range(0, 8'hBF)), 8'($urandom));
      add_req(1, 8'($urandom_range(0, 8'hBF)), 8'($urandom));
    end
    model_run();
    wait_idle(200);

    // Locked interrupt-router write is dropped, ordinary write goes through.
    irq_lock = 1'b1;
    add_req(0, 8'hC3, 8'h55);
    add_req(0, 8'h20, 8'h66);
    model_run();
    wait_idle(100);
    check("drop_after_lock", drop_cnt, 1);

    for (int ph = 0; ph < 10; ph++) begin
      irq_lock = 1'($urandom_range(0, 1));
      for (int p = 0; p < NUM_REQ; p++) begin
        n = $urandom_range(0, 5);
        for (int j = 0; j < n; j++) add_req(p, 8'($urandom), 8'($urandom));
      end
      model_run();
      wait_idle(200);
    end

    // Saturation of the drop counter.
    irq_lock = 1'b1;
    for (int j = 0; j < 300; j++) add_req(0, 8'($urandom_range(8'hC0, 8'hFF)), 8'($urandom));
    for (int j = 0; j < 20; j++) add_req(1, 8'($urandom), 8'($urandom));
    model_run();
    wait_idle(1500);
    check("drop_saturated", drop_cnt, 255);

    // Terminator at entry 1, with host requests pending throughout boot.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    reset_checks("reset2");
    rom_mem[1] = 16'hFFFF;
    irq_lock = 1'b0;
    model_reset();
    done = push_boot();
    for (int j = 0; j < 3; j++) begin
      add_req(0, 8'($urandom), 8'($urandom));
      add_req(1, 8'($urandom), 8'($urandom));
    end
    model_run();
    @(negedge clk);
    rst = 1'b0;
    wait_done(done);
    wait_idle(200);

    // Reset lands on the HOST_WRITE edge of a grant to port 0.
    rom_mem[1] = 16'h1022;
    hold_drv = 1'b1;
    @(negedge clk);
    bus_if.req_valid       = 2'b01;
    bus_if.req_addr[7:0]   = 8'h31;
    bus_if.req_wdata[7:0]  = 8'h77;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("midgrant");
    model_reset();
    done = push_boot();
    add_req(0, 8'h31, 8'h77);
    add_req(1, 8'h42, 8'h88);
    add_req(0, 8'h43, 8'h99);
    model_run();
    hold_drv = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    wait_done(done);
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d vectors, %0d miscompares", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
